// File: rtl/scene_ctrl.sv
// scene_ctrl: menu/game scene sequencer with fade-out, start/ready handshake, fade-in
// and a single registered, attenuated RGB output path.
module scene_ctrl #(
   parameter int FRAMES_PER_STEP = 4,
   parameter int TIMEOUT_FRAMES  = 120
) (
   input  logic        i_clk_pix,
   input  logic        i_rst,
   input  logic        i_frame,
   input  logic        i_start,
   input  logic        i_main_ready,
   input  logic        i_game_over,
   input  logic        i_menu_drawing,
   input  logic [23:0] i_menu_rgb,
   input  logic        i_game_drawing,
   input  logic [23:0] i_game_rgb,
   output logic        o_main_start,
   output logic        o_menu_active,
   output logic        o_game_active,
   output logic        o_timeout,
   output logic [3:0]  o_fade,
   output logic [2:0]  o_state,
   output logic        o_drawing,
   output logic [7:0]  o_red,
   output logic [7:0]  o_green,
   output logic [7:0]  o_blue
);
   localparam int SW = $clog2(FRAMES_PER_STEP + 1);
   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
   typedef enum logic [2:0] {
      S_MENU     = 3'd0,
      S_FADE_OUT = 3'd1,
      S_START    = 3'd2,
      S_FADE_IN  = 3'd3,
      S_GAME     = 3'd4
   } state_t;
   state_t        state_q, state_d;
   logic [3:0]    fade_q, fade_d;
   logic [SW-1:0] step_q, step_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          start_prev_q;
   logic          main_start_q, main_start_d;
   logic          menu_active_q, menu_active_d;
   logic          game_active_q, game_active_d;
   logic          timeout_q, timeout_d;
   logic          drawing_q, drawing_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          start_edge, step_last, tmo_last;
   logic          src_draw;
   logic [23:0]   src_rgb;
   assign start_edge = i_start & ~start_prev_q;
   assign step_last  = step_q == SW'(FRAMES_PER_STEP - 1);
   assign tmo_last   = tmo_q == TW'(TIMEOUT_FRAMES - 1);
   always_ff @(posedge i_clk_pix) begin
      if (i_rst) begin
         state_q       <= S_MENU;
         fade_q        <= '0;
         step_q        <= '0;
         tmo_q         <= '0;
         start_prev_q  <= 1'b1;
         main_start_q  <= 1'b0;
         menu_active_q <= 1'b1;
         game_active_q <= 1'b0;
         timeout_q     <= 1'b0;
         drawing_q     <= 1'b0;
         rgb_q         <= '0;
      end else begin
         state_q       <= state_d;
         fade_q        <= fade_d;
         step_q        <= step_d;
         tmo_q         <= tmo_d;
         start_prev_q  <= i_start;
         main_start_q  <= main_start_d;
         menu_active_q <= menu_active_d;
         game_active_q <= game_active_d;
         timeout_q     <= timeout_d;
         drawing_q     <= drawing_d;
         rgb_q         <= rgb_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      fade_d    = fade_q;
      step_d    = step_q;
      tmo_d     = tmo_q;
      timeout_d = 1'b0;
      case (state_q)
         S_MENU: begin
            fade_d = '0;
            if (start_edge) state_d = S_FADE_OUT;
         end
         S_FADE_OUT: if (i_frame) begin
            step_d = step_last ? '0 : step_q + SW'(1);
            if (step_last) begin
               fade_d = fade_q + 4'd1;
               if (fade_q == 4'd7) state_d = S_START;
            end
         end
         S_START: if (i_main_ready) state_d = S_FADE_IN;
         else if (i_frame) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_last) begin
               timeout_d = 1'b1;
               fade_d    = '0;
               state_d   = S_MENU;
            end
         end
         S_FADE_IN: if (i_frame) begin
            step_d = step_last ? '0 : step_q + SW'(1);
            if (step_last) begin
               fade_d = fade_q - 4'd1;
               if (fade_q == 4'd1) state_d = S_GAME;
            end
         end
         S_GAME: if (i_game_over) begin
            state_d = S_MENU;
            fade_d  = '0;
         end
         default: begin
            state_d = S_MENU;
            fade_d  = '0;
         end
      endcase
      // every state starts with fresh step and timeout counts
      if (state_d != state_q) begin
         step_d = '0;
         tmo_d  = '0;
      end
   end
   always_comb begin
      main_start_d  = state_d == S_START;
      menu_active_d = state_d == S_MENU || state_d == S_FADE_OUT;
      game_active_d = state_d == S_FADE_IN || state_d == S_GAME;
      src_draw      = state_q == S_START ? 1'b1 :
                      (state_q == S_FADE_IN || state_q == S_GAME) ? i_game_drawing : i_menu_drawing;
      src_rgb       = state_q == S_START ? 24'h0 :
                      (state_q == S_FADE_IN || state_q == S_GAME) ? i_game_rgb : i_menu_rgb;
      drawing_d     = src_draw;
      rgb_d         = src_draw ? {src_rgb[23:16] >> fade_q, src_rgb[15:8] >> fade_q, src_rgb[7:0] >> fade_q} : 24'h0;
   end
   assign o_main_start  = main_start_q;
   assign o_menu_active = menu_active_q;
   assign o_game_active = game_active_q;
   assign o_timeout     = timeout_q;
   assign o_fade        = fade_q;
   assign o_state       = state_q;
   assign o_drawing     = drawing_q;
   assign o_red         = rgb_q[23:16];
   assign o_green       = rgb_q[15:8];
   assign o_blue        = rgb_q[7:0];
endmodule

// File: tb/tb_scene_ctrl.sv
// tb_scene_ctrl: directed vector table plus hand-written fade, handshake, timeout and reset sequences.
module tb_scene_ctrl;
   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_frame = 1'b0;
   logic        i_start = 1'b1;
   logic        i_main_ready = 1'b0;
   logic        i_game_over = 1'b0;
   logic        i_menu_drawing = 1'b1;
   logic [23:0] i_menu_rgb = 24'hFF8040;
   logic        i_game_drawing = 1'b1;
   logic [23:0] i_game_rgb = 24'h808080;
   logic        o_main_start, o_menu_active, o_game_active, o_timeout, o_drawing;
   logic [3:0]  o_fade;
   logic [2:0]  o_state;
   logic [7:0]  o_red, o_green, o_blue;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   scene_ctrl #(.FRAMES_PER_STEP(2), .TIMEOUT_FRAMES(5)) dut (
      .i_clk_pix(clk), .i_rst(i_rst), .i_frame(i_frame), .i_start(i_start),
      .i_main_ready(i_main_ready), .i_game_over(i_game_over),
      .i_menu_drawing(i_menu_drawing), .i_menu_rgb(i_menu_rgb),
      .i_game_drawing(i_game_drawing), .i_game_rgb(i_game_rgb),
      .o_main_start(o_main_start), .o_menu_active(o_menu_active), .o_game_active(o_game_active),
      .o_timeout(o_timeout), .o_fade(o_fade), .o_state(o_state), .o_drawing(o_drawing),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
   );
   typedef struct {
      logic       rst, start, frame;
      logic [2:0] st;
      logic [3:0] fade;
      logic       ms, draw;
      logic [7:0] red;
   } vec_t;
   vec_t vecs[10];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick(input logic f);
      i_frame = f;
      @(posedge clk);
      #1;
      i_frame = 1'b0;
   endtask
   task automatic pulse();
      tick(1'b1);
      tick(1'b0);
   endtask
   task automatic press();
      i_start = 1'b0;
      tick(1'b0);
      i_start = 1'b1;
      tick(1'b0);
   endtask
   task automatic chk_reset();
      chk("rst_state", o_state, 0);
      chk("rst_fade", o_fade, 0);
      chk("rst_main_start", o_main_start, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_menu_active", o_menu_active, 1);
      chk("rst_game_active", o_game_active, 0);
      chk("rst_drawing", o_drawing, 0);
      chk("rst_rgb", {o_red, o_green, o_blue}, 0);
   endtask
   initial begin
      logic [7:0] ff, c80, c40;
      int f;
      //          rst   start frame st    fade  ms    draw  red
      vecs[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 8'hFF};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 8'hFF};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 8'hFF};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0, 1'b1, 8'hFF};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 1'b0, 1'b1, 8'hFF};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 3'd1, 4'd1, 1'b0, 1'b1, 8'hFF};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd1, 4'd1, 1'b0, 1'b1, 8'h7F};
      vecs[9] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd1, 1'b0, 1'b1, 8'h7F};
      ff = 8'hFF;
      c80 = 8'h80;
      c40 = 8'h40;
      for (int i = 0; i < 10; i++) begin
         i_rst = vecs[i].rst;
         i_start = vecs[i].start;
         tick(vecs[i].frame);
         chk($sformatf("vec%0d_state", i), o_state, vecs[i].st);
         chk($sformatf("vec%0d_fade", i), o_fade, vecs[i].fade);
         chk($sformatf("vec%0d_main_start", i), o_main_start, vecs[i].ms);
         chk($sformatf("vec%0d_drawing", i), o_drawing, vecs[i].draw);
         chk($sformatf("vec%0d_red", i), o_red, vecs[i].red);
         if (i == 1) chk_reset();
      end
      for (int n = 3; n <= 16; n++) begin
         tick(1'b1);
         if (n == 16) begin
            chk("fo_enter_start", o_state, 2);
            chk("fo_main_start", o_main_start, 1);
         end
         tick(1'b0);
         f = n / 2;
         chk($sformatf("fo%0d_fade", n), o_fade, f);
         chk($sformatf("fo%0d_red", n), o_red, ff >> f);
         chk($sformatf("fo%0d_green", n), o_green, c80 >> f);
         chk($sformatf("fo%0d_blue", n), o_blue, c40 >> f);
      end
      for (int k = 0; k < 3; k++) begin
         pulse();
         chk("hs_state", o_state, 2);
         chk("hs_main_start", o_main_start, 1);
      end
      i_main_ready = 1'b1;
      tick(1'b0);
      i_main_ready = 1'b0;
      chk("hs_fade_in", o_state, 3);
      chk("hs_start_drop", o_main_start, 0);
      chk("hs_black", {o_red, o_green, o_blue}, 0);
      chk("hs_black_draw", o_drawing, 1);
      i_game_over = 1'b1;
      tick(1'b0);
      i_game_over = 1'b0;
      chk("go_ignored", o_state, 3);
      for (int n = 1; n <= 16; n++) begin
         pulse();
         f = 8 - n / 2;
         chk($sformatf("fi%0d_fade", n), o_fade, f);
         chk($sformatf("fi%0d_red", n), o_red, c80 >> f);
         chk($sformatf("fi%0d_blue", n), o_blue, c80 >> f);
      end
      chk("fi_game", o_state, 4);
      chk("fi_game_active", o_game_active, 1);
      chk("fi_menu_inactive", o_menu_active, 0);
      i_game_over = 1'b1;
      tick(1'b0);
      i_game_over = 1'b0;
      chk("go_menu", o_state, 0);
      chk("go_menu_active", o_menu_active, 1);
      chk("go_game_active", o_game_active, 0);
      chk("go_fade", o_fade, 0);
      press();
      chk("to_press", o_state, 1);
      repeat (16) pulse();
      chk("to_start", o_state, 2);
      for (int k = 1; k <= 4; k++) begin
         tick(1'b1);
         chk($sformatf("to_wait%0d", k), o_timeout, 0);
         chk($sformatf("to_state%0d", k), o_state, 2);
         tick(1'b0);
      end
      tick(1'b1);
      chk("to_pulse", o_timeout, 1);
      chk("to_menu", o_state, 0);
      chk("to_fade", o_fade, 0);
      chk("to_start_drop", o_main_start, 0);
      tick(1'b0);
      chk("to_one_cycle", o_timeout, 0);
      press();
      repeat (16) pulse();
      chk("rw_start", o_state, 2);
      repeat (4) pulse();
      i_main_ready = 1'b1;
      tick(1'b1);
      i_main_ready = 1'b0;
      chk("rw_fade_in", o_state, 3);
      chk("rw_no_timeout", o_timeout, 0);
      tick(1'b0);
      chk("rw_no_timeout2", o_timeout, 0);
      repeat (6) pulse();
      chk("mid_fade", o_fade, 5);
      chk("mid_state", o_state, 3);
      i_rst = 1'b1;
      tick(1'b0);
      chk_reset();
      i_rst = 1'b0;
      tick(1'b0);
      chk("post_rst_state", o_state, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
